gpioemu_master: RTL and testbench

Bus initiator for the gpioemu multiplier peripheral. For each accepted command it writes operand A to 0x108 and operand B to 0x110, polls the busy register at 0x128 until it reads clear, then reads W (0x118) and L (0x120) and returns them on a result handshake. It sits between on-chip logic and the gpioemu register bus, and issues in hardware the same transaction sequence a software driver would.

---
 rtl/gpioemu_master.sv | 231 +++++++++++++++++++++++
 tb/tb_gpioemu_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_master.sv
// gpioemu_master
//
// Hardware bus initiator for the gpioemu multiplier peripheral. For every
// accepted command it runs the same register sequence a software driver
// would: write A to 0x108, write B to 0x110, poll the busy register 0x128
// until bit 0 reads clear, then read W (0x118) and L (0x120) and present
// them on a valid/ready result handshake.
//
// Every bus transaction is SETUP (1 cycle, strobes low) -> STROBE
// (STROBE_LEN cycles, srd or swr high) -> HOLD (1 cycle, strobes low).
// Read data is captured on the clock edge that ends HOLD.
//
// Optional feature macro: GPIOEMU_MASTER_TIMEOUT_EN
//   defined   : a poll counter limits busy polls to POLL_MAX; on expiry the
//               master skips the W/L reads and completes with res_err=1.
//   undefined : the master polls forever, res_err is tied low.
//
// Parameters:
//   STROBE_LEN  cycles a strobe is held high (>=1)
//   POLL_GAP    idle cycles between consecutive busy polls (>=0)
//   POLL_MAX    busy polls allowed per command (timeout build only)
//
// Ports:
//   clk, reset             clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready    command handshake, cmd_a/cmd_b 24-bit operands
//   res_valid/res_ready    result handshake, res_w/res_l/res_err payload
//   saddress, srd, swr     peripheral address and strobes
//   sdata_out              write data to the peripheral
//   sdata_in               read data from the peripheral

module gpioemu_master #(
  parameter int STROBE_LEN = 1,
  parameter int POLL_GAP   = 2,
  parameter int POLL_MAX   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a,
  input  logic [23:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [31:0] res_l,
  output logic        res_err,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  // Parameter sanity, caught at elaboration.
  if (STROBE_LEN < 1 || POLL_GAP < 0 || POLL_MAX < 1) begin : g_bad_param
    $error("gpioemu_master: STROBE_LEN>=1, POLL_GAP>=0, POLL_MAX>=1 required");
  end

  localparam logic [15:0] ADDR_A    = 16'h0108;
  localparam logic [15:0] ADDR_B    = 16'h0110;
  localparam logic [15:0] ADDR_W    = 16'h0118;
  localparam logic [15:0] ADDR_L    = 16'h0120;
  localparam logic [15:0] ADDR_BUSY = 16'h0128;

  // One shared down-counter serves both the strobe phase and the poll gap;
  // size it for whichever is longer.
  localparam int CNT_MAX = (STROBE_LEN > POLL_GAP) ? STROBE_LEN : POLL_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] STB_LAST = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, POLL, GAP, RD_W, RD_L, DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP, PH_STROBE, PH_HOLD
  } phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [23:0]   b_q;     // A goes out at accept time, only B needs keeping

`ifdef GPIOEMU_MASTER_TIMEOUT_EN
  localparam int PCW = ($clog2(POLL_MAX + 1) > 8) ? $clog2(POLL_MAX + 1) : 8;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
  logic [PCW-1:0] poll_cnt;   // polls completed for the current command
  logic           err_q;
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  // Both handshake flags are pure state decodes; cmd_ready is also gated by
  // reset so it stays low while reset is asserted.
  assign cmd_ready = (state == IDLE) && !reset;
  assign res_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= PH_SETUP;
      cnt       <= '0;
      b_q       <= '0;
      saddress  <= '0;
      sdata_out <= '0;
      srd       <= 1'b0;
      swr       <= 1'b0;
      res_w     <= '0;
      res_l     <= '0;
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
      poll_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // The accept edge already sets up the WR_A transaction, so
            // SETUP of WR_A is the first cycle after acceptance.
            b_q       <= cmd_b;
            res_w     <= '0;
            res_l     <= '0;
            saddress  <= ADDR_A;
            sdata_out <= {8'h00, cmd_a};
            phase     <= PH_SETUP;
            state     <= WR_A;
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
            poll_cnt  <= '0;
            err_q     <= 1'b0;
`endif
          end
        end

        GAP: begin
          // Address stays on 0x128 during the gap; the next poll starts
          // directly in SETUP.
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            phase <= PH_SETUP;
            state <= POLL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (res_ready) state <= IDLE;
        end

        default: begin
          // WR_A, WR_B, POLL, RD_W, RD_L: one bus transaction each.
          case (phase)
            PH_SETUP: begin
              cnt   <= '0;
              phase <= PH_STROBE;
              if (state == WR_A || state == WR_B) swr <= 1'b1;
              else                                srd <= 1'b1;
            end

            PH_STROBE: begin
              if (cnt == STB_LAST) begin
                srd   <= 1'b0;
                swr   <= 1'b0;
                phase <= PH_HOLD;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end

            PH_HOLD: begin
              // End of transaction: capture read data and set up the
              // next transaction's address/data for its SETUP cycle.
              phase <= PH_SETUP;
              case (state)
                WR_A: begin
                  state     <= WR_B;
                  saddress  <= ADDR_B;
                  sdata_out <= {8'h00, b_q};
                end
                WR_B: begin
                  state     <= POLL;
                  saddress  <= ADDR_BUSY;
                  sdata_out <= '0;
                end
                POLL: begin
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
                  poll_cnt <= poll_cnt + 1'b1;
`endif
                  // Only bit 0 of the busy word carries status.
                  if (!sdata_in[0]) begin
                    state    <= RD_W;
                    saddress <= ADDR_W;
                  end
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
                  else if (poll_cnt == POLL_LAST) begin
                    // Still busy after the last allowed poll: give up
                    // without reading W/L (they stay cleared).
                    err_q <= 1'b1;
                    state <= DONE;
                  end
`endif
                  else if (POLL_GAP == 0) begin
                    state <= POLL;
                  end else begin
                    cnt   <= '0;
                    state <= GAP;
                  end
                end
                RD_W: begin
                  res_w    <= sdata_in;
                  state    <= RD_L;
                  saddress <= ADDR_L;
                end
                RD_L: begin
                  res_l <= sdata_in;
                  state <= DONE;
                end
                default: state <= IDLE;
              endcase
            end

            default: phase <= PH_SETUP;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpioemu_master.sv
// Self-checking bench for gpioemu_master: a small multiplier peripheral
// model answers the bus, and a transaction-level reference model predicts
// the bus sequence, its cycle timing and the result of every command.

module tb_gpioemu_master;

  localparam int SL  = 1;
  localparam int GP  = 2;
  localparam int PM  = 4;
  localparam int T   = SL + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_a = '0;
  logic [23:0] cmd_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_w, res_l;
  logic        res_err;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;

  always #5 clk = ~clk;

  gpioemu_master #(.STROBE_LEN(SL), .POLL_GAP(GP), .POLL_MAX(PM)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_w(res_w), .res_l(res_l), .res_err(res_err),
    .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_out(sdata_out), .sdata_in(sdata_in)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic [23:0] pa = '0, pb = '0;
  int          busy_polls = 0;   // polls that report busy for this command
  int          poll_seen = 0;
  logic [30:0] noise = '0;       // junk in ignored bits of the busy word
  logic        srd_q = 1'b0;
  logic [47:0] prod;
  logic        busy_bit;

  always @(posedge clk) begin
    noise <= 31'($urandom);
    srd_q <= srd;
    if (swr && saddress == 16'h0108) begin pa <= sdata_out[23:0]; poll_seen <= 0; end
    if (swr && saddress == 16'h0110) pb <= sdata_out[23:0];
    if (srd && !srd_q && saddress == 16'h0128) poll_seen <= poll_seen + 1;
  end

  assign prod     = {24'h0, pa} * {24'h0, pb};
  assign busy_bit = (poll_seen <= busy_polls);

  always_comb begin
    case (saddress)
      16'h0118: sdata_in = prod[31:0];
      16'h0120: sdata_in = {16'h0, prod[47:32]};
      16'h0128: sdata_in = {noise, busy_bit};
      default:  sdata_in = {noise, 1'b0};
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct { bit wr; logic [15:0] addr; logic [31:0] data; int cyc; } txn_t;
  typedef struct { logic [23:0] a; logic [23:0] b; int busy; } cmd_t;

  txn_t        exp_q[$];
  cmd_t        cmd_q[$];
  int          exp_done;
  logic [31:0] exp_w, exp_l;
  bit          exp_err;

  // Cycle numbering: the cycle ending with the accept edge is cycle 0.
  function automatic void build(input cmd_t c);
    int s = 1;
    int np;
    bit err = 0;
    logic [47:0] p;
    exp_q.delete();
    exp_q.push_back('{1'b1, 16'h0108, {8'h0, c.a}, s + 1}); s += T;
    exp_q.push_back('{1'b1, 16'h0110, {8'h0, c.b}, s + 1}); s += T;
    np = c.busy + 1;
`ifdef GPIOEMU_MASTER_TIMEOUT_EN
    if (c.busy >= PM) begin np = PM; err = 1; end
`endif
    for (int i = 0; i < np; i++) begin
      exp_q.push_back('{1'b0, 16'h0128, 32'h0, s + 1}); s += T;
      if (i < np - 1) s += GP;
    end
    if (!err) begin
      exp_q.push_back('{1'b0, 16'h0118, 32'h0, s + 1}); s += T;
      exp_q.push_back('{1'b0, 16'h0120, 32'h0, s + 1}); s += T;
    end
    exp_done = s;
    p = {24'h0, c.a} * {24'h0, c.b};
    exp_w   = err ? 32'h0 : p[31:0];
    exp_l   = err ? 32'h0 : {16'h0, p[47:32]};
    exp_err = err;
  endfunction

  // ---------------- compare process ----------------
  bit          m_busy = 0, prev_acc = 0, prev_hs = 0, prev_str = 0, seen_rv = 0;
  bit          exp_rv, cur;
  int          cidx = 0, str_cnt = 0;
  int          obs_done = 0, obs_polls = 0, obs_rd = 0;
  logic [31:0] obs_w = '0, obs_wrb = '0;
  logic        obs_err = 1'b0;
  cmd_t        cur_cmd;
  txn_t        t;

  always @(negedge clk) begin
    if (reset) begin
      m_busy = 0; prev_acc = 0; prev_hs = 0; prev_str = 0; seen_rv = 0;
      cidx = 0; exp_q.delete();
    end else begin
      if (prev_hs) m_busy = 0;
      if (prev_acc) begin
        if (cmd_q.size() > 0) cur_cmd = cmd_q.pop_front();
        build(cur_cmd);
        m_busy = 1; seen_rv = 0; cidx = 1;
        obs_polls = 0; obs_rd = 0;
      end else begin
        cidx++;
      end
      exp_rv = m_busy && (cidx >= exp_done);
      chk("res_valid", 32'(res_valid), 32'(exp_rv));
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("strobe_excl", 32'(srd && swr), 32'h0);

      cur = srd || swr;
      if (cur && !prev_str) begin
        if (srd && saddress == 16'h0128) obs_polls++;
        if (srd && (saddress == 16'h0118 || saddress == 16'h0120)) obs_rd++;
        if (swr && saddress == 16'h0110) obs_wrb = sdata_out;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_txn: got addr 0x%04h at cycle %0d want no transaction", saddress, cidx);
        end else begin
          t = exp_q.pop_front();
          chk("txn_kind", 32'(swr), 32'(t.wr));
          chk("txn_addr", 32'(saddress), 32'(t.addr));
          chk("txn_data", sdata_out, t.data);
          chk("txn_cycle", cidx, t.cyc);
        end
        str_cnt = 1;
      end else if (cur) begin
        str_cnt++;
      end
      if (!cur && prev_str) chk("strobe_len", str_cnt, SL);

      if (exp_rv) begin
        chk("res_w", res_w, exp_w);
        chk("res_l", res_l, exp_l);
        chk("res_err", 32'(res_err), 32'(exp_err));
        chk("done_quiet", 32'({srd, swr}), 32'h0);
        if (!seen_rv) begin
          seen_rv = 1;
          chk("txns_left", exp_q.size(), 0);
          obs_done = cidx; obs_w = res_w; obs_err = res_err;
        end
      end
      prev_str = cur;
      prev_hs  = exp_rv && res_ready;
      prev_acc = cmd_valid && !m_busy;
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [23:0] a, input logic [23:0] b,
                         input int busy, input int rdly, input bit pester);
    int n;
    bit rdy;
    cmd_t c;
    c.a = a; c.b = b; c.busy = busy;
    cmd_q.push_back(c);
    busy_polls = busy;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
    n = 0;
    do begin
      rdy = cmd_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 100);
    cmd_valid = 1'b0; cmd_a = 24'($urandom); cmd_b = 24'($urandom);
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got cmd_ready=0 want 1 within 100 cycles");
      cmd_q.delete();
      return;
    end
    if (pester) begin
      // cmd_valid while busy must be ignored, not queued.
      repeat (2) begin @(posedge clk); #1; end
      cmd_valid = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      cmd_valid = 1'b0;
    end
    n = 0;
    while (!res_valid && n < 2000) begin @(posedge clk); #1; n++; end
    if (!res_valid) begin
      checks++; failures++;
      $display("FAIL result_timeout: got res_valid=0 want 1 within 2000 cycles");
      return;
    end
    repeat (rdly) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    int n;
    cmd_t c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_saddress", 32'(saddress), 32'h0);
    chk("rst_sdata_out", sdata_out, 32'h0);
    chk("rst_strobes", 32'({srd, swr}), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_w", res_w, 32'h0);
    reset = 1'b0;
    #1 chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // Basic command, no busy polls.
    run_cmd(24'd2, 24'd7, 0, 0, 0);
    chk("t1_done_cycle", obs_done, 16);
    chk("t1_res_w", obs_w, 32'hE);
    chk("t1_polls", obs_polls, 1);

    run_cmd(24'hED, 24'hFA, 0, 1, 0);
    chk("t2_res_w", obs_w, 32'h0000E772);
    chk("t2_res_err", 32'(obs_err), 32'h0);
    chk("t2_wrb_data", obs_wrb, 32'h000000FA);

    // Three busy polls with a 2-cycle gap.
    run_cmd(24'd3, 24'd5, 3, 0, 0);
    chk("t3_done_cycle", obs_done, 31);
    chk("t3_polls", obs_polls, 4);

`ifdef GPIOEMU_MASTER_TIMEOUT_EN
    run_cmd(24'd9, 24'd9, 50, 0, 0);
    chk("to_polls", obs_polls, 4);
    chk("to_res_err", 32'(obs_err), 32'h1);
    chk("to_res_w", obs_w, 32'h0);
    chk("to_reads", obs_rd, 0);
    chk("to_done_cycle", obs_done, 25);
`endif

    // Stalled result consumer plus ignored cmd_valid while busy.
    run_cmd(24'd11, 24'd13, 1, 10, 1);
    chk("stall_res_w", obs_w, 32'd143);

    // Reset in the middle of the WR_B strobe.
    c.a = 24'd5; c.b = 24'd6; c.busy = 0;
    cmd_q.push_back(c);
    busy_polls = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = c.a; cmd_b = c.b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!(swr && saddress == 16'h0110) && n < 50) begin @(negedge clk); n++; end
    chk("rst_mid_found_wrb", 32'(swr && saddress == 16'h0110), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_swr", 32'(swr), 32'h0);
    chk("rst_mid_saddress", 32'(saddress), 32'h0);
    chk("rst_mid_sdata_out", sdata_out, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'h1);
    run_cmd(24'd1, 24'd1, 0, 0, 0);
    chk("rst_mid_res_w", obs_w, 32'h1);

    // Randomized commands.
    for (int i = 0; i < 20; i++) begin
      run_cmd(24'($urandom), 24'($urandom), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
